// File: rtl/m_decomp.sv
// m_decomp: receive side of a WIDTH:1 mux path. It steps the mux select through
// 0..WIDTH-1, samples the single mux output bit for each select value and rebuilds
// the parallel word sitting on the mux data inputs, then presents it with a done strobe.
// Optional build macro M_DECOMP_AUTO_EN: after the first start the block rescans forever.
module m_decomp #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  // Settle counter is sized for at least one bit so SETTLE of 0 or 1 still elaborates.
  localparam int CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_LAST);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_scan_first;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [WIDTH-1:0]   r_d_out;
  logic [WIDTH-1:0]   w_d_out_nxt;
  logic [WIDTH-1:0]   r_shadow;
  logic [WIDTH-1:0]   w_shadow_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cnt_last;
  logic               w_sel_last;

  // First state of every scan: skip SETTLE entirely when no settle time is configured.
  assign w_scan_first = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  assign w_cnt_last   = (r_cnt == CNT_LAST);
  assign w_sel_last   = (r_sel == SEL_LAST);

  // State and registered outputs; async reset aborts any scan and discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d_out  <= '0;
      r_shadow <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_d_out  <= w_d_out_nxt;
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state: start is honoured only in IDLE, so it is ignored while busy and in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = w_scan_first;
      S_SETTLE: if (w_cnt_last) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = w_sel_last ? S_DONE : w_scan_first;
`ifdef M_DECOMP_AUTO_EN
      S_DONE:   w_state_nxt = w_scan_first;
`else
      S_DONE:   w_state_nxt = S_IDLE;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; the last sampled bit is merged
  // straight into d_out so the DONE cycle already shows the complete word.
  always_comb begin
    w_sel_nxt    = r_sel;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_d_out_nxt  = r_d_out;
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sel_nxt  = '0;
          w_busy_nxt = 1'b1;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = w_cnt_last ? '0 : r_cnt + 1'b1;
      end
      S_SAMPLE: begin
        w_shadow_nxt[r_sel] = y_in;
        if (w_sel_last) begin
          w_d_out_nxt = w_shadow_nxt;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_sel_nxt   = '0;
        end else begin
          w_sel_nxt = r_sel + 1'b1;
        end
      end
      S_DONE: begin
`ifdef M_DECOMP_AUTO_EN
        w_sel_nxt  = '0;
        w_busy_nxt = 1'b1;
`else
        w_sel_nxt  = '0;
        w_busy_nxt = 1'b0;
`endif
      end
      default: begin
        w_sel_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign sel   = r_sel;
  assign busy  = r_busy;
  assign done  = r_done;
  assign d_out = r_d_out;

endmodule

// File: tb/tb_m_decomp.sv
// Directed bench for m_decomp: a behavioural mux feeds y_in from d_model[sel].
// Two instances share clock and reset: SETTLE=1 (main) and SETTLE=0.
module tb_m_decomp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start0;
  logic [3:0] d_model;
  logic       y_in, y_in0;
  logic [1:0] sel, sel0;
  logic       busy, busy0, done, done0;
  logic [3:0] d_out, d_out0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y_in  = d_model[sel];
  assign y_in0 = d_model[sel0];

  m_decomp #(.WIDTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .sel(sel), .busy(busy), .done(done), .d_out(d_out)
  );

  m_decomp #(.WIDTH(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y_in0),
    .sel(sel0), .busy(busy0), .done(done0), .d_out(d_out0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen or the budget runs out; returns edges taken.
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      step();
      edges++;
      if (done) break;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; start0 = 1'b0; d_model = 4'b0000;
    #1 rst_n = 1'b0;
    step();
    checks++;
    if ({sel, busy, done, d_out} !== 8'h00) begin
      errors++;
      $display("FAIL reset_main got sel=%0d busy=%0b done=%0b d_out=%b want all 0", sel, busy, done, d_out);
    end
    checks++;
    if ({sel0, busy0, done0, d_out0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_s0 got sel=%0d busy=%0b done=%0b d_out=%b want all 0", sel0, busy0, done0, d_out0);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_scan_basic();
    logic [1:0] exp_sel;
    d_model = 4'b0101;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || sel !== 2'd0) begin
      errors++;
      $display("FAIL accept got busy=%0b sel=%0d want busy=1 sel=0", busy, sel);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_sel = (k == 8) ? 2'd0 : 2'(k / 2);
      checks++;
      if (sel !== exp_sel || done !== (k == 8)) begin
        errors++;
        $display("FAIL scan_edge%0d got sel=%0d done=%0b want sel=%0d done=%0b", k, sel, done, exp_sel, (k == 8));
      end
    end
    checks++;
    if (d_out !== 4'b0101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_word got d_out=%b busy=%0b want 0101 busy=0", d_out, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || d_out !== 4'b0101) begin
      errors++;
      $display("FAIL scan_after got done=%0b d_out=%b want done=0 d_out=0101", done, d_out);
    end
  endtask

  task automatic test_two_scans();
    logic [3:0] pats [2];
    int n;
    pats[0] = 4'b1110;
    pats[1] = 4'b0001;
    for (int p = 0; p < 2; p++) begin
      d_model = pats[p];
      pulse_start();
      wait_done(20, n);
      checks++;
      if (n !== 8 || d_out !== pats[p]) begin
        errors++;
        $display("FAIL two_scans%0d got edges=%0d d_out=%b want 8 %b", p, n, d_out, pats[p]);
      end
      d_model = ~pats[p];
      repeat (4) step();
      checks++;
      if (d_out !== pats[p] || done !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d got d_out=%b done=%0b want %b done=0", p, d_out, done, pats[p]);
      end
    end
  endtask

  task automatic test_start_held();
    int ndone;
    int n;
    d_model = 4'b1011;
    ndone = 0;
    // start stays high from the accept edge through the DONE cycle
    start = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) begin
      step();
      if (done) ndone++;
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 1 || busy !== 1'b0 || d_out !== 4'b1011) begin
      errors++;
      $display("FAIL start_held got dones=%0d busy=%0b d_out=%b want 1 0 1011", ndone, busy, d_out);
    end
    // a start pulse landing in the DONE cycle must not launch a scan
    d_model = 4'b0111;
    pulse_start();
    wait_done(20, n);
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done || busy) ndone++;
    end
    checks++;
    if (n !== 8 || ndone !== 0 || d_out !== 4'b0111) begin
      errors++;
      $display("FAIL start_in_done got edges=%0d activity=%0d d_out=%b want 8 0 0111", n, ndone, d_out);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int n;
    d_model = 4'b0110;
    pulse_start();
    guard = 0;
    while (sel !== 2'd2 && guard < 10) begin
      step();
      guard++;
    end
    checks++;
    if (sel !== 2'd2) begin
      errors++;
      $display("FAIL reach_sel2 got sel=%0d want 2", sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || d_out !== 4'b0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort got sel=%0d busy=%0b d_out=%b done=%0b want 0 0 0000 0", sel, busy, d_out, done);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d_out !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset got busy=%0b done=%0b d_out=%b want 0 0 0000", busy, done, d_out);
    end
    pulse_start();
    wait_done(20, n);
    checks++;
    if (n !== 8 || d_out !== 4'b0110) begin
      errors++;
      $display("FAIL rescan got edges=%0d d_out=%b want 8 0110", n, d_out);
    end
    step();
  endtask

  task automatic test_settle0();
    int n;
    d_model = 4'b1010;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (done0) break;
    end
    checks++;
    if (n !== 4 || d_out0 !== 4'b1010) begin
      errors++;
      $display("FAIL settle0 got edges=%0d d_out=%b want 4 1010", n, d_out0);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || d_out0 !== 4'b1010) begin
      errors++;
      $display("FAIL settle0_after got done=%0b d_out=%b want 0 1010", done0, d_out0);
    end
  endtask

`ifdef M_DECOMP_AUTO_EN
  task automatic test_auto();
    int n;
    d_model = 4'b0101;
    pulse_start();
    wait_done(20, n);
    checks++;
    if (n !== 8 || d_out !== 4'b0101) begin
      errors++;
      $display("FAIL auto_first got edges=%0d d_out=%b want 8 0101", n, d_out);
    end
    wait_done(20, n);
    checks++;
    if (n !== 9 || d_out !== 4'b0101) begin
      errors++;
      $display("FAIL auto_second got edges=%0d d_out=%b want 9 0101", n, d_out);
    end
    d_model = 4'b0011;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_busy got busy=%0b want 1", busy);
    end
    wait_done(20, n);
    checks++;
    if (n !== 8 || d_out !== 4'b0011) begin
      errors++;
      $display("FAIL auto_third got edges=%0d d_out=%b want 8 0011", n, d_out);
    end
    wait_done(20, n);
    checks++;
    if (n !== 9 || d_out !== 4'b0011) begin
      errors++;
      $display("FAIL auto_fourth got edges=%0d d_out=%b want 9 0011", n, d_out);
    end
    wait_done(20, n);
    checks++;
    if (n !== 9 || d_out !== 4'b0011) begin
      errors++;
      $display("FAIL auto_fifth got edges=%0d d_out=%b want 9 0011", n, d_out);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef M_DECOMP_AUTO_EN
    test_auto();
`else
    test_scan_basic();
    test_two_scans();
    test_start_held();
    test_reset_mid();
`endif
    test_settle0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
